// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Holds the fetch-to-decode entry layout, its bus width and the default reset PC.
// Optional feature macro used by this slice: IF_FETCH_BYPASS_EN (see if_fetch_buffer_fifo).
package if_fetch_buffer_pkg;

  localparam int unsigned PC_WD   = 32;
  localparam int unsigned INST_WD = 32;
  localparam int unsigned ADEF_WD = 1;

  localparam int unsigned FS_TO_DS_BUS_WD = PC_WD + INST_WD + ADEF_WD;

  localparam logic [PC_WD-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  // One buffered instruction as seen by decode.
  typedef struct packed {
    logic [PC_WD-1:0]   pc;
    logic [INST_WD-1:0] inst;
    logic               adef;
  } fetch_entry_t;

  function automatic logic [PC_WD-1:0] next_seq_pc(input logic [PC_WD-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with flush, occupancy count and optional bypass.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           empties the FIFO at the next edge (a same-cycle push is dropped)
//   push, push_data write request and entry
//   pop_ready       consumer accepts the head this cycle
//   out_valid       head valid; out_data head entry; count current occupancy
// Macro IF_FETCH_BYPASS_EN: when defined, a push into an empty FIFO while the consumer is
// ready is forwarded combinationally to the output and never stored.
module if_fetch_buffer_fifo
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [FS_TO_DS_BUS_WD-1:0] push_data,
  input  logic                       pop_ready,
  output logic                       out_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [FS_TO_DS_BUS_WD-1:0] mem [DEPTH];
  logic [PtrW-1:0]            rptr_q, wptr_q;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       empty, bypass, do_write, do_read;

  assign empty = (cnt_q == '0);

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = empty && push && pop_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign do_write  = push && !bypass;
  assign do_read   = !empty && pop_ready;
  assign out_valid = !empty || bypass;
  assign out_data  = bypass ? push_data : mem[rptr_q];
  assign count     = cnt_q;

  always_comb begin
    cnt_d = cnt_q + CntW'(do_write) - CntW'(do_read);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_write) wptr_q <= wptr_q + PtrW'(1);
      if (do_read)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (do_write && !flush) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer between the icache request port and decode.
// Issues sequential fetches with up to MAX_OUTST in flight, queues returned instructions in
// a DEPTH-entry FIFO and hands them to decode with a valid/allowin handshake. A redirect
// flushes the FIFO and turns every in-flight request into a stale one whose response is
// later dropped.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//   idle_req, has_int               idle lock set / released by a pending interrupt
//   inst_valid, inst_addr           icache request; inst_addr_ok accepts it
//   inst_data_ok, inst_rdata        icache response, returned in request order
//   fs_to_ds_valid, ds_allowin      decode handshake; fs_pc, fs_inst, fs_excp_adef head entry
// Macro IF_FETCH_BYPASS_EN: zero-latency response forwarding (implemented in the FIFO).
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        idle_req,
  input  logic        has_int,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fs_to_ds_valid,
  input  logic        ds_allowin,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_excp_adef
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned QW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CntW:0]   OutstLim = (CntW + 1)'(MAX_OUTST);
  localparam logic [CntW:0]   DepthLim = (CntW + 1)'(DEPTH);
  localparam logic [QW-1:0]   QLast    = QW'(MAX_OUTST - 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outst_cnt_q, outst_cnt_d;
  logic [CntW-1:0] stale_cnt_q, stale_cnt_d;
  logic [CntW-1:0] fifo_cnt;
  logic            idle_lock_q, idle_lock_d;
  logic            adef_lock_q, adef_lock_d;

  // PCs of live in-flight requests, oldest at rptr.
  logic [31:0]     pcq_mem [MAX_OUTST];
  logic [QW-1:0]   pcq_rptr_q, pcq_wptr_q;

  logic [CntW:0]   inflight, occupancy;
  logic            pc_aligned, accept, resp_stale, resp_live, adef_push, fifo_push;
  fetch_entry_t    push_entry, head_entry;
  logic            head_valid;

  assign inflight   = {1'b0, outst_cnt_q} + {1'b0, stale_cnt_q};
  // A live outstanding request already owns a FIFO slot.
  assign occupancy  = {1'b0, fifo_cnt} + {1'b0, outst_cnt_q};
  assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);

  assign inst_valid = !reset && !idle_lock_q && !adef_lock_q && !redirect_valid && pc_aligned &&
                      (inflight < OutstLim) && (occupancy < DepthLim);
  assign inst_addr  = fetch_pc_q;

  assign accept     = inst_valid && inst_addr_ok;
  assign resp_stale = inst_data_ok && (stale_cnt_q != '0);
  assign resp_live  = inst_data_ok && (stale_cnt_q == '0);
  // Misaligned PC: deliver an address-error entry instead of fetching, then stop.
  assign adef_push  = !reset && !pc_aligned && !adef_lock_q && !redirect_valid &&
                      (occupancy < DepthLim);
  assign fifo_push  = resp_live || adef_push;

  always_comb begin
    push_entry = '0;
    if (adef_push) begin
      push_entry.pc   = fetch_pc_q;
      push_entry.inst = 32'h0;
      push_entry.adef = 1'b1;
    end else begin
      push_entry.pc   = pcq_mem[pcq_rptr_q];
      push_entry.inst = inst_rdata;
      push_entry.adef = 1'b0;
    end
  end

  always_comb begin
    outst_cnt_d = outst_cnt_q + CntW'(accept) - CntW'(resp_live);
    stale_cnt_d = stale_cnt_q - CntW'(resp_stale);
    fetch_pc_d  = accept ? next_seq_pc(fetch_pc_q) : fetch_pc_q;
    adef_lock_d = adef_lock_q || adef_push;
    if (redirect_valid) begin
      // Everything still live after this cycle becomes stale.
      stale_cnt_d = stale_cnt_d + outst_cnt_d;
      outst_cnt_d = '0;
      fetch_pc_d  = redirect_pc;
      adef_lock_d = 1'b0;
    end
    idle_lock_d = idle_lock_q;
    if (has_int)       idle_lock_d = 1'b0;
    else if (idle_req) idle_lock_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      outst_cnt_q <= '0;
      stale_cnt_q <= '0;
      idle_lock_q <= 1'b0;
      adef_lock_q <= 1'b0;
      pcq_rptr_q  <= '0;
      pcq_wptr_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      outst_cnt_q <= outst_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      idle_lock_q <= idle_lock_d;
      adef_lock_q <= adef_lock_d;
      if (redirect_valid) begin
        pcq_rptr_q <= '0;
        pcq_wptr_q <= '0;
      end else begin
        if (accept)    pcq_wptr_q <= (pcq_wptr_q == QLast) ? '0 : pcq_wptr_q + QW'(1);
        if (resp_live) pcq_rptr_q <= (pcq_rptr_q == QLast) ? '0 : pcq_rptr_q + QW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcq_mem[pcq_wptr_q] <= fetch_pc_q;
  end

  if_fetch_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop_ready(ds_allowin),
    .out_valid(head_valid),
    .out_data (head_entry),
    .count    (fifo_cnt)
  );

  assign fs_to_ds_valid = head_valid;
  assign fs_pc          = head_entry.pc;
  assign fs_inst        = head_entry.inst;
  assign fs_excp_adef   = head_valid && head_entry.adef;

  resp_has_request: assert property (@(posedge clk) disable iff (reset)
    inst_data_ok |-> (inflight != '0));

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        idle_req, has_int;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fs_to_ds_valid, ds_allowin;
  logic [31:0] fs_pc, fs_inst;
  logic        fs_excp_adef;

  always #5 clk = ~clk;

  if_fetch_buffer #(
    .DEPTH    (DEPTH),
    .MAX_OUTST(MAX_OUTST),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .idle_req      (idle_req),
    .has_int       (has_int),
    .inst_valid    (inst_valid),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .fs_to_ds_valid(fs_to_ds_valid),
    .ds_allowin    (ds_allowin),
    .fs_pc         (fs_pc),
    .fs_inst       (fs_inst),
    .fs_excp_adef  (fs_excp_adef)
  );

  typedef struct { logic [31:0] pc; logic stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;

  // Model: requests in flight (oldest first), buffered entries, fetch state.
  req_t        pend[$];
  ent_t        fifo[$];
  ent_t        dut_log[$];
  logic [31:0] m_pc;
  logic        m_idle, m_adef_lock;

  int          checks = 0;
  int          errors = 0;
  logic        addr_ok_en, resp_en;
  logic        capture_accept;
  logic [31:0] first_accept_addr;
  int          valid_hi_cnt;
  int          base;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] pc,
                           input logic [31:0] inst, input logic adef);
    if (idx >= dut_log.size()) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_entry expected=pc_%h", name, pc);
    end else begin
      check({name, "_pc"}, dut_log[idx].pc, pc);
      check({name, "_inst"}, dut_log[idx].inst, inst);
      check({name, "_adef"}, 32'(dut_log[idx].adef), 32'(adef));
    end
  endtask

  // One clock cycle: drive the icache side, compare at negedge, advance the model.
  task automatic step();
    int   live_out, fifo_n;
    logic e_valid, resp, resp_live, bypass, e_head_valid;
    ent_t head, rent, obs, aent;
    req_t nreq;
    inst_addr_ok = addr_ok_en;
    inst_data_ok = resp_en && (pend.size() != 0);
    inst_rdata   = (pend.size() != 0) ? mem(pend[0].pc) : 32'h0;
    @(negedge clk);
    if (reset) begin
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_fs_to_ds_valid", 32'(fs_to_ds_valid), 32'd0);
      check("rst_fs_excp_adef", 32'(fs_excp_adef), 32'd0);
      pend.delete();
      fifo.delete();
      m_pc = RESET_PC;
      m_idle = 1'b0;
      m_adef_lock = 1'b0;
    end else begin
      live_out = 0;
      foreach (pend[i]) if (!pend[i].stale) live_out++;
      fifo_n = fifo.size();
      e_valid = !m_idle && !m_adef_lock && !redirect_valid && (m_pc[1:0] == 2'b00) &&
                (pend.size() < MAX_OUTST) && (fifo_n + live_out < DEPTH);
      resp = inst_data_ok;
      resp_live = 1'b0;
      rent = '{pc: 32'h0, inst: 32'h0, adef: 1'b0};
      if (resp) begin
        resp_live = !pend[0].stale;
        rent = '{pc: pend[0].pc, inst: inst_rdata, adef: 1'b0};
      end
      bypass = 1'b0;
`ifdef IF_FETCH_BYPASS_EN
      bypass = (fifo_n == 0) && ds_allowin && resp_live && !redirect_valid;
`endif
      e_head_valid = (fifo_n != 0) || bypass;
      head = bypass ? rent : ((fifo_n != 0) ? fifo[0] : '{pc: 32'h0, inst: 32'h0, adef: 1'b0});

      check("inst_valid", 32'(inst_valid), 32'(e_valid));
      if (e_valid) check("inst_addr", inst_addr, m_pc);
      check("fs_to_ds_valid", 32'(fs_to_ds_valid), 32'(e_head_valid));
      if (e_head_valid) begin
        check("fs_pc", fs_pc, head.pc);
        check("fs_inst", fs_inst, head.inst);
      end
      check("fs_excp_adef", 32'(fs_excp_adef), 32'(e_head_valid && head.adef));

      // Observed DUT traffic for the hand-computed checks.
      if (fs_to_ds_valid && ds_allowin) begin
        obs = '{pc: fs_pc, inst: fs_inst, adef: fs_excp_adef};
        dut_log.push_back(obs);
      end
      if (inst_valid) valid_hi_cnt++;
      if (capture_accept && inst_valid && inst_addr_ok) begin
        first_accept_addr = inst_addr;
        capture_accept = 1'b0;
      end

      if ((fifo_n != 0) && ds_allowin) void'(fifo.pop_front());
      if (resp) begin
        void'(pend.pop_front());
        if (resp_live && !bypass) fifo.push_back(rent);
      end
      if ((m_pc[1:0] != 2'b00) && !m_adef_lock && !redirect_valid &&
          (fifo_n + live_out < DEPTH)) begin
        aent = '{pc: m_pc, inst: 32'h0, adef: 1'b1};
        fifo.push_back(aent);
        m_adef_lock = 1'b1;
      end
      if (e_valid && inst_addr_ok) begin
        nreq = '{pc: m_pc, stale: 1'b0};
        pend.push_back(nreq);
        m_pc = m_pc + 32'd4;
      end
      if (has_int)       m_idle = 1'b0;
      else if (idle_req) m_idle = 1'b1;
      if (redirect_valid) begin
        fifo.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_pc = redirect_pc;
        m_adef_lock = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    idle_req = 1'b0;
    has_int = 1'b0;
    ds_allowin = 1'b1;
    addr_ok_en = 1'b0;
    resp_en = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    capture_accept = 1'b0;
    first_accept_addr = 32'h0;
    valid_hi_cnt = 0;
    m_pc = RESET_PC;
    m_idle = 1'b0;
    m_adef_lock = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();

    // Sequential streaming after reset.
    reset = 1'b0;
    addr_ok_en = 1'b1;
    resp_en = 1'b1;
    repeat (10) step();
    check_log("t1_e0", 0, 32'h1c00_0000, 32'he3ff_ffff, 1'b0);
    check_log("t1_e1", 1, 32'h1c00_0004, 32'he3ff_fffb, 1'b0);
    check_log("t1_e2", 2, 32'h1c00_0008, 32'he3ff_fff7, 1'b0);

    // Fill the FIFO with decode stalled, then drain.
    ds_allowin = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0200;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    check("t2_full_inst_valid", 32'(inst_valid), 32'd0);
    check("t2_full_head_pc", fs_pc, 32'h1c00_0200);
    base = dut_log.size();
    capture_accept = 1'b1;
    ds_allowin = 1'b1;
    repeat (8) step();
    check("t2_restart_addr", first_accept_addr, 32'h1c00_0210);
    check_log("t2_d0", base, 32'h1c00_0200, 32'he3ff_fdff, 1'b0);
    check_log("t2_d3", base + 3, 32'h1c00_020c, 32'he3ff_fdf3, 1'b0);
    check_log("t2_d4", base + 4, 32'h1c00_0210, 32'he3ff_fdef, 1'b0);

    // Redirect with two requests outstanding.
    resp_en = 1'b0;
    repeat (6) step();
    check("t3_outst_limit_inst_valid", 32'(inst_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0100;
    step();
    redirect_valid = 1'b0;
    base = dut_log.size();
    resp_en = 1'b1;
    repeat (8) step();
    check_log("t3_first", base, 32'h1c00_0100, 32'he3ff_feff, 1'b0);

    // Redirect while addr_ok and data_ok are both active.
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0300;
    step();
    redirect_valid = 1'b0;
    base = dut_log.size();
    repeat (6) step();
    check_log("t4_first", base, 32'h1c00_0300, 32'he3ff_fcff, 1'b0);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0102;
    step();
    redirect_valid = 1'b0;
    base = dut_log.size();
    valid_hi_cnt = 0;
    repeat (16) step();
    check_log("t5_adef", base, 32'h1c00_0102, 32'h0000_0000, 1'b1);
    check("t5_no_fetch", 32'(valid_hi_cnt), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c00_0400;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();

    // Idle lock and interrupt release.
    idle_req = 1'b1;
    step();
    idle_req = 1'b0;
    valid_hi_cnt = 0;
    repeat (20) step();
    check("t6_idle_no_fetch", 32'(valid_hi_cnt), 32'd0);
    has_int = 1'b1;
    step();
    has_int = 1'b0;
    check("t6_resume", 32'(inst_valid), 32'd1);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Parametrised successor to the single-outstanding pre-IF/IF pair.
- Sits between the icache request port and the decode stage.
- Issues sequential fetch requests with up to MAX_OUTST in flight, buffers returned instructions in a DEPTH-entry FIFO, and presents them to decode with a valid/allowin handshake.
- Redirects (exception, ertn, refetch, branch mispredict) squash the buffer. In-flight responses that a redirect makes stale are counted and discarded, so no replay state machines are needed.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, ≥2
MAX_OUTST, 2, maximum outstanding icache requests; 1..DEPTH
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
redirect_valid  in  1  flush/redirect pulse from WB or ID
redirect_pc  in  32  new fetch PC
idle_req  in  1  idle committed; stop issuing
has_int  in  1  pending interrupt; releases idle lock
inst_valid  out  1  icache request valid
inst_addr  out  32  request address
inst_addr_ok  in  1  request accepted
inst_data_ok  in  1  response valid (in request order)
inst_rdata  in  32  response instruction
fs_to_ds_valid  out  1  buffer head valid
ds_allowin  in  1  decode accepts head
fs_pc  out  32  head PC
fs_inst  out  32  head instruction
fs_excp_adef  out  1  head carries address-error (misaligned PC)

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc=RESET_PC; outst_cnt, stale_cnt, FIFO count/pointers and idle_lock all 0; adef_lock=0.
  - Outputs inst_valid=0, fs_to_ds_valid=0, fs_excp_adef=0; fs_pc/fs_inst are don't-care.
- Issue condition:
  - inst_valid = !idle_lock && !adef_lock && !redirect_valid && fetch_pc[1:0]==0 && (outst_cnt+stale_cnt)<MAX_OUTST && (fifo_cnt+outst_cnt)<DEPTH.
  - inst_addr=fetch_pc.
  - Once inst_valid rises, it and inst_addr stay stable until inst_addr_ok, unless a redirect arrives.
- Accept: inst_valid&&inst_addr_ok -> fetch_pc+=4; push fetch_pc into the internal PC queue (MAX_OUTST deep); outst_cnt++.
- Response with stale_cnt>0: stale_cnt--; data dropped.
- Response with stale_cnt==0: pop the PC queue, enqueue {pc,rdata,adef=0} into the FIFO, outst_cnt--.
- A response with no request outstanding is illegal (assertion).
- Misaligned fetch_pc:
  - Nothing is sent to the icache.
  - When fifo_cnt+outst_cnt<DEPTH, enqueue {fetch_pc, 32'h0, adef=1} and set adef_lock.
  - Fetch stays stopped until a redirect.
- Dequeue: fs_to_ds_valid = fifo_cnt!=0; pop on fs_to_ds_valid&&ds_allowin.
  - Simultaneous push and pop at full is legal; fifo_cnt is unchanged.
- Redirect, same cycle:
  - FIFO emptied; stale_cnt += outst_cnt, counting a request accepted this cycle and excluding a response consumed this cycle.
  - outst_cnt=0; PC queue cleared; fetch_pc=redirect_pc; adef_lock=0.
  - inst_valid is forced 0 in the redirect cycle; issue resumes next cycle.
- Idle: idle_req&&!has_int sets idle_lock; has_int clears it. A redirect does not clear idle_lock.
- Widths: counters are clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Optional Feature:
IF_FETCH_BYPASS_EN
- Defined: if the FIFO is empty, ds_allowin=1 and a non-stale response arrives, the response drives fs_to_ds_valid/fs_pc/fs_inst combinationally in the same cycle and is not enqueued. Latency from inst_data_ok to decode is 0 cycles.
- Undefined: all responses are registered; latency from inst_data_ok to fs_to_ds_valid is 1 cycle.

Decomposition:
- Shared package (mycpu.h):
  - FS_TO_DS_BUS_WD update.
  - Entry field widths (PC 32, INST 32, ADEF 1).
  - RESET_PC default.
- Natural sub-module: fetch_fifo, a generic DEPTH-parametrised sync FIFO with flush, count, push/pop, and an optional bypass mux.
- Counters and issue logic stay in the top.

Test Plan:
- Reset, zero-latency addr_ok and 1-cycle data_ok, ds_allowin=1 -> requests issued to 1c000000, 1c000004, 1c000008 back-to-back; decode receives them in order; outst_cnt never exceeds 2.
- ds_allowin=0 with DEPTH=4 -> FIFO fills to 4, inst_valid drops while fifo_cnt+outst_cnt=4; raising ds_allowin drains 4 entries and issue restarts at the next sequential PC.
- Two requests outstanding, redirect_pc=1c000100 -> two subsequent data_ok responses are dropped (stale_cnt 2→0); the first instruction delivered has fs_pc=1c000100.
- Redirect in the same cycle as inst_addr_ok and another data_ok -> stale_cnt is counted correctly and no stale PC reaches decode.
- redirect_pc=1c000102 -> no icache request; decode receives fs_pc=1c000102 with fs_excp_adef=1; no further fetch until the next redirect.
- idle_req with has_int=0 -> inst_valid stays 0 for 20 cycles; has_int=1 -> fetch resumes the following cycle.
